// File: rtl/decode_stage.sv
// Registered decode stage of the 16-bit RISC core.
// Decodes one instruction per cycle and holds issue while a scoreboarded register is pending.
module decode_stage #(
   parameter int NREGS = 8,
   parameter int IW    = 16
) (
   input  logic                     I_clk,
   input  logic                     I_rst_n,
   input  logic                     I_en,
   input  logic [IW-1:0]            I_instr,
   input  logic                     I_valid,
   output logic                     O_ready,
   output logic                     O_valid,
   input  logic                     I_ready,
   output logic [$clog2(NREGS)-1:0] O_selA,
   output logic [$clog2(NREGS)-1:0] O_selB,
   output logic [$clog2(NREGS)-1:0] O_selD,
   output logic                     O_regDwe,
   output logic [4:0]               O_aluop,
   output logic [IW-1:0]            O_imm,
   output logic                     O_illegal,
   input  logic                     I_wb_valid,
   input  logic [$clog2(NREGS)-1:0] I_wb_sel
);

   localparam int SW = $clog2(NREGS);

   logic [3:0]    opc;
   logic [SW-1:0] rd;
   logic [SW-1:0] ra;
   logic [SW-1:0] rb;
   logic          flag;
   logic [7:0]    imm8;

   assign opc  = I_instr[15:12];
   assign rd   = I_instr[11:9];
   assign flag = I_instr[8];
   assign ra   = I_instr[7:5];
   assign rb   = I_instr[4:2];
   assign imm8 = I_instr[7:0];

   logic          dwe_d;
   logic          illegal_d;
   logic [IW-1:0] imm_d;

   always_comb begin
      dwe_d     = 1'b0;
      illegal_d = 1'b0;
      unique case (opc)
         4'h0, 4'h1, 4'h2, 4'h3,
         4'h4, 4'h5, 4'h6:        dwe_d = 1'b1;
         4'h8, 4'h9, 4'hA, 4'hB:  dwe_d = 1'b1;
         4'hE, 4'hF:              illegal_d = 1'b1;
         default:                 dwe_d = 1'b0;
      endcase
   end

   // LOAD places imm8 in either byte; everything else uses a 5-bit field
   always_comb begin
      imm_d = {{(IW-5){1'b0}}, I_instr[4:0]};
      if (opc == 4'h8) begin
         if (flag)
            imm_d = {imm8, 8'h00};
         else
            imm_d = {8'h00, imm8};
      end
   end

   logic [NREGS-1:0] sb_q;
   logic [NREGS-1:0] sb_d;
   logic [NREGS-1:0] clr;
   logic [NREGS-1:0] set;
   logic [NREGS-1:0] one;
   logic             hz;
   logic             accept;
   logic             valid_q;

   assign one = {{(NREGS-1){1'b0}}, 1'b1};

   // Hazard looks only at registered state; writeback clears show next cycle
   assign hz      = I_valid & (sb_q[ra] | sb_q[rb] | sb_q[rd]);
   assign O_ready = I_en & ~hz & (~valid_q | I_ready);
   assign accept  = I_valid & O_ready;

   assign clr  = I_wb_valid ? (one << I_wb_sel) : '0;
   assign set  = (accept & dwe_d) ? (one << rd) : '0;
   assign sb_d = (sb_q & ~clr) | set;

   logic [SW-1:0] selA_q;
   logic [SW-1:0] selB_q;
   logic [SW-1:0] selD_q;
   logic          dwe_q;
   logic [4:0]    aluop_q;
   logic [IW-1:0] imm_q;
   logic          illegal_q;

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         sb_q      <= '0;
         valid_q   <= 1'b0;
         selA_q    <= '0;
         selB_q    <= '0;
         selD_q    <= '0;
         dwe_q     <= 1'b0;
         aluop_q   <= '0;
         imm_q     <= '0;
         illegal_q <= 1'b0;
      end else if (I_en) begin
         sb_q <= sb_d;
         if (accept) begin
            valid_q   <= 1'b1;
            selA_q    <= ra;
            selB_q    <= rb;
            selD_q    <= rd;
            dwe_q     <= dwe_d;
            aluop_q   <= {opc, flag};
            imm_q     <= imm_d;
            illegal_q <= illegal_d;
         end else if (valid_q & I_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign O_valid   = valid_q;
   assign O_selA    = selA_q;
   assign O_selB    = selB_q;
   assign O_selD    = selD_q;
   assign O_regDwe  = dwe_q;
   assign O_aluop   = aluop_q;
   assign O_imm     = imm_q;
   assign O_illegal = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage.
// Each task drives one scenario and checks against hand-computed values.
module tb_decode_stage;

   logic        I_clk;
   logic        I_rst_n;
   logic        I_en;
   logic [15:0] I_instr;
   logic        I_valid;
   logic        O_ready;
   logic        O_valid;
   logic        I_ready;
   logic [2:0]  O_selA;
   logic [2:0]  O_selB;
   logic [2:0]  O_selD;
   logic        O_regDwe;
   logic [4:0]  O_aluop;
   logic [15:0] O_imm;
   logic        O_illegal;
   logic        I_wb_valid;
   logic [2:0]  I_wb_sel;

   int checks;
   int failures;

   decode_stage #(.NREGS(8), .IW(16)) dut (
      .I_clk      (I_clk),
      .I_rst_n    (I_rst_n),
      .I_en       (I_en),
      .I_instr    (I_instr),
      .I_valid    (I_valid),
      .O_ready    (O_ready),
      .O_valid    (O_valid),
      .I_ready    (I_ready),
      .O_selA     (O_selA),
      .O_selB     (O_selB),
      .O_selD     (O_selD),
      .O_regDwe   (O_regDwe),
      .O_aluop    (O_aluop),
      .O_imm      (O_imm),
      .O_illegal  (O_illegal),
      .I_wb_valid (I_wb_valid),
      .I_wb_sel   (I_wb_sel)
   );

   initial I_clk = 1'b0;
   always #5 I_clk = ~I_clk;

   task automatic tick;
      @(posedge I_clk);
      #1;
   endtask

   task automatic do_reset;
      I_rst_n    = 1'b0;
      I_en       = 1'b1;
      I_valid    = 1'b0;
      I_ready    = 1'b1;
      I_instr    = 16'h0000;
      I_wb_valid = 1'b0;
      I_wb_sel   = 3'd0;
      tick();
      I_rst_n = 1'b1;
   endtask

   task automatic test_reset;
      I_rst_n = 1'b1;
      #2;
      do_reset();
      checks++;
      if (O_valid !== 1'b0 || O_regDwe !== 1'b0 || O_imm !== 16'h0 ||
          O_aluop !== 5'h0 || O_illegal !== 1'b0 || O_selD !== 3'd0) begin
         failures++;
         $display("FAIL reset_state valid=%b dwe=%b imm=%h aluop=%h",
                  O_valid, O_regDwe, O_imm, O_aluop);
      end
      I_instr = 16'h0A24;
      I_valid = 1'b1;
      tick();
      I_valid = 1'b0;
      checks++;
      if (O_valid !== 1'b1) begin
         failures++;
         $display("FAIL reset_pre_valid got=%b exp=1", O_valid);
      end
      #3;
      I_rst_n = 1'b0;
      #1;
      checks++;
      if (O_valid !== 1'b0 || O_regDwe !== 1'b0 || O_imm !== 16'h0 ||
          O_selD !== 3'd0) begin
         failures++;
         $display("FAIL async_reset valid=%b dwe=%b imm=%h seld=%0d exp 0",
                  O_valid, O_regDwe, O_imm, O_selD);
      end
      @(negedge I_clk);
      I_rst_n = 1'b1;
      I_instr = 16'h02A0;
      I_valid = 1'b1;
      #1;
      checks++;
      if (O_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_sb_clear ready got=%b exp=1", O_ready);
      end
      I_valid = 1'b0;
   endtask

   task automatic test_basic;
      do_reset();
      I_instr = 16'h0A24;
      I_valid = 1'b1;
      #1;
      checks++;
      if (O_ready !== 1'b1) begin
         failures++;
         $display("FAIL basic_ready got=%b exp=1", O_ready);
      end
      tick();
      I_valid = 1'b0;
      checks++;
      if (O_valid !== 1'b1 || O_selD !== 3'd5 || O_selA !== 3'd1 ||
          O_selB !== 3'd1 || O_regDwe !== 1'b1 || O_aluop !== 5'b00000 ||
          O_imm !== 16'h0004 || O_illegal !== 1'b0) begin
         failures++;
         $display("FAIL basic_decode v=%b d=%0d a=%0d b=%0d we=%b op=%b imm=%h exp 1/5/1/1/1/00000/0004",
                  O_valid, O_selD, O_selA, O_selB, O_regDwe, O_aluop, O_imm);
      end
      tick();
      checks++;
      if (O_valid !== 1'b0 || O_selD !== 3'd5 || O_imm !== 16'h0004) begin
         failures++;
         $display("FAIL basic_drain v=%b d=%0d imm=%h exp 0/5/0004",
                  O_valid, O_selD, O_imm);
      end
   endtask

   task automatic test_load;
      do_reset();
      I_instr = 16'h89AB;
      I_valid = 1'b1;
      tick();
      I_valid = 1'b0;
      checks++;
      if (O_imm !== 16'hAB00 || O_regDwe !== 1'b1 || O_aluop !== 5'b10001 ||
          O_selD !== 3'd4 || O_selA !== 3'd5 || O_selB !== 3'd2) begin
         failures++;
         $display("FAIL load_high imm=%h we=%b op=%b d=%0d exp AB00/1/10001/4",
                  O_imm, O_regDwe, O_aluop, O_selD);
      end
      do_reset();
      I_instr = 16'h80AB;
      I_valid = 1'b1;
      tick();
      I_valid = 1'b0;
      checks++;
      if (O_imm !== 16'h00AB || O_aluop !== 5'b10000) begin
         failures++;
         $display("FAIL load_low imm=%h op=%b exp 00AB/10000", O_imm, O_aluop);
      end
   endtask

   task automatic test_raw;
      do_reset();
      I_instr = 16'h0A24;
      I_valid = 1'b1;
      tick();
      I_instr = 16'h02A0;
      #1;
      checks++;
      if (O_ready !== 1'b0) begin
         failures++;
         $display("FAIL raw_stall0 ready got=%b exp=0", O_ready);
      end
      tick();
      checks++;
      if (O_ready !== 1'b0 || O_valid !== 1'b0) begin
         failures++;
         $display("FAIL raw_stall1 ready=%b valid=%b exp 0/0", O_ready, O_valid);
      end
      I_wb_valid = 1'b1;
      I_wb_sel   = 3'd5;
      #1;
      checks++;
      if (O_ready !== 1'b0) begin
         failures++;
         $display("FAIL raw_no_bypass ready got=%b exp=0", O_ready);
      end
      tick();
      I_wb_valid = 1'b0;
      checks++;
      if (O_ready !== 1'b1) begin
         failures++;
         $display("FAIL raw_release ready got=%b exp=1", O_ready);
      end
      tick();
      I_valid = 1'b0;
      checks++;
      if (O_valid !== 1'b1 || O_selA !== 3'd5 || O_selD !== 3'd1) begin
         failures++;
         $display("FAIL raw_issue v=%b a=%0d d=%0d exp 1/5/1",
                  O_valid, O_selA, O_selD);
      end
   endtask

   task automatic test_backpressure;
      do_reset();
      I_instr = 16'h0A24;
      I_valid = 1'b1;
      tick();
      I_ready = 1'b0;
      I_instr = 16'h1470;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (O_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready[%0d] got=%b exp=0", i, O_ready);
         end
         tick();
         checks++;
         if (O_valid !== 1'b1 || O_selD !== 3'd5 || O_selA !== 3'd1 ||
             O_selB !== 3'd1 || O_imm !== 16'h0004 || O_aluop !== 5'b00000 ||
             O_regDwe !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold[%0d] v=%b d=%0d a=%0d imm=%h exp 1/5/1/0004",
                     i, O_valid, O_selD, O_selA, O_imm);
         end
      end
      I_ready = 1'b1;
      #1;
      checks++;
      if (O_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release ready got=%b exp=1", O_ready);
      end
      tick();
      I_valid = 1'b0;
      checks++;
      if (O_valid !== 1'b1 || O_selD !== 3'd2 || O_selA !== 3'd3 ||
          O_selB !== 3'd4 || O_imm !== 16'h0010 || O_aluop !== 5'b00010) begin
         failures++;
         $display("FAIL bp_next v=%b d=%0d a=%0d b=%0d imm=%h op=%b exp 1/2/3/4/0010/00010",
                  O_valid, O_selD, O_selA, O_selB, O_imm, O_aluop);
      end
   endtask

   task automatic test_collision_illegal;
      do_reset();
      I_wb_valid = 1'b1;
      I_wb_sel   = 3'd3;
      I_instr    = 16'h0600;
      I_valid    = 1'b1;
      tick();
      I_wb_valid = 1'b0;
      I_instr    = 16'h0060;
      #1;
      checks++;
      if (O_ready !== 1'b0) begin
         failures++;
         $display("FAIL collision_sb3 ready got=%b exp=0", O_ready);
      end
      I_instr = 16'h0000;
      #1;
      checks++;
      if (O_ready !== 1'b1) begin
         failures++;
         $display("FAIL collision_r0_free ready got=%b exp=1", O_ready);
      end
      I_instr = 16'hF000;
      tick();
      I_valid = 1'b0;
      checks++;
      if (O_illegal !== 1'b1 || O_regDwe !== 1'b0 || O_aluop !== 5'b11110 ||
          O_valid !== 1'b1) begin
         failures++;
         $display("FAIL illegal_decode ill=%b we=%b op=%b v=%b exp 1/0/11110/1",
                  O_illegal, O_regDwe, O_aluop, O_valid);
      end
      I_instr = 16'h0000;
      I_valid = 1'b1;
      #1;
      checks++;
      if (O_ready !== 1'b1) begin
         failures++;
         $display("FAIL illegal_no_sb ready got=%b exp=1", O_ready);
      end
      I_instr = 16'h0060;
      #1;
      checks++;
      if (O_ready !== 1'b0) begin
         failures++;
         $display("FAIL illegal_sb3_kept ready got=%b exp=0", O_ready);
      end
      I_valid = 1'b0;
   endtask

   task automatic test_enable;
      do_reset();
      I_en    = 1'b0;
      I_instr = 16'h0A24;
      I_valid = 1'b1;
      #1;
      checks++;
      if (O_ready !== 1'b0) begin
         failures++;
         $display("FAIL en_ready got=%b exp=0", O_ready);
      end
      tick();
      checks++;
      if (O_valid !== 1'b0) begin
         failures++;
         $display("FAIL en_hold valid got=%b exp=0", O_valid);
      end
      I_en = 1'b1;
      I_instr = 16'h02A0;
      #1;
      checks++;
      if (O_ready !== 1'b1) begin
         failures++;
         $display("FAIL en_no_sb ready got=%b exp=1", O_ready);
      end
      I_valid = 1'b0;
   endtask

   task automatic test_opcodes;
      logic [15:0] dwe_mask;
      logic [15:0] ill_mask;
      logic [3:0]  op;
      dwe_mask = 16'h0F7F;
      ill_mask = 16'hC000;
      for (int i = 0; i < 16; i++) begin
         op = 4'(i);
         do_reset();
         I_instr = {op, 12'h000};
         I_valid = 1'b1;
         tick();
         I_valid = 1'b0;
         checks++;
         if (O_regDwe !== dwe_mask[i] || O_illegal !== ill_mask[i] ||
             O_aluop !== {op, 1'b0} || O_imm !== 16'h0000) begin
            failures++;
            $display("FAIL opcode_%h we=%b ill=%b op=%b imm=%h exp we=%b ill=%b",
                     op, O_regDwe, O_illegal, O_aluop, O_imm,
                     dwe_mask[i], ill_mask[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      do_reset();
      I_valid = 1'b1;
      I_instr = 16'h0A24;
      tick();
      I_instr = 16'h1470;
      #1;
      checks++;
      if (O_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_ready got=%b exp=1", O_ready);
      end
      tick();
      I_valid = 1'b0;
      checks++;
      if (O_valid !== 1'b1 || O_selD !== 3'd2 || O_imm !== 16'h0010) begin
         failures++;
         $display("FAIL b2b_second v=%b d=%0d imm=%h exp 1/2/0010",
                  O_valid, O_selD, O_imm);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic();
      test_load();
      test_raw();
      test_backpressure();
      test_collision_illegal();
      test_enable();
      test_opcodes();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered instruction decode stage of the 16-bit RISC core. Sits directly upstream of the register file.
- Accepts a fetched 16-bit instruction and produces the register file's select/write-enable controls, plus ALU opcode, immediate and flags.
- Tracks outstanding register writes in an 8-entry scoreboard. Stalls issue on RAW/WAW hazards until writeback clears them.

Parameters:
- NREGS, 8, number of architectural registers; fixes select width at 3 and scoreboard width at 8.
- IW, 16, instruction and data width.

Ports:
- I_clk  in  1  clock; all state updates on rising edge.
- I_rst_n  in  1  reset, asynchronous, active-low.
- I_en  in  1  stage enable; when 0, all state holds and O_ready=0.
- I_instr  in  16  instruction from fetch.
- I_valid  in  1  I_instr valid.
- O_ready  out  1  stage accepts I_instr this cycle.
- O_valid  out  1  decoded outputs valid.
- I_ready  in  1  downstream (regfile/ALU) accepts decoded bundle.
- O_selA  out  3  regfile read port A select.
- O_selB  out  3  regfile read port B select.
- O_selD  out  3  regfile write select.
- O_regDwe  out  1  regfile write enable for this instruction.
- O_aluop  out  5  {opcode[3:0], flag}.
- O_imm  out  16  immediate.
- O_illegal  out  1  opcode 0xE/0xF.
- I_wb_valid  in  1  writeback to regfile occurring.
- I_wb_sel  in  3  register being written back.

Behaviour:
- Reset (async, I_rst_n=0): O_valid=0, O_selA/B/D=0, O_regDwe=0, O_aluop=0, O_imm=0, O_illegal=0, scoreboard=0. Reset mid-handshake drops any held bundle; no partial state survives.
- Encoding:
  - opcode=instr[15:12], rD=[11:9], flag=[8], rA=[7:5], rB=[4:2], imm8=[7:0].
  - O_selA=rA, O_selB=rB, O_selD=rD, O_aluop={opcode,flag}.
- O_regDwe: 1 for opcodes 0x0-0x6 and 0x8-0xB; 0 for 0x7 and 0xC-0xF.
- O_imm:
  - Opcode 0x8 (LOAD): flag=1 gives {imm8,8'h00}; flag=0 gives {8'h00,imm8}.
  - All other opcodes: {11'b0, instr[4:0]}.
- Hazard: hz = I_valid & (sb[rA] | sb[rB] | sb[rD]), evaluated on the registered scoreboard only. A same-cycle writeback does not bypass; the clear is visible next cycle.
- O_ready = I_en & ~hz & (~O_valid | I_ready). Combinational.
- Accept (I_valid & O_ready), 1-cycle latency: next edge loads the decoded bundle and sets O_valid=1.
- Drain: if O_valid & I_ready with no accept, O_valid<=0 next edge. Outputs other than O_valid hold their last value.
- Stall: O_valid & ~I_ready holds every output stable. The bundle must not change while O_valid=1 and I_ready=0.
- Scoreboard update, on edge with I_en=1:
  - clr = I_wb_valid ? onehot(I_wb_sel) : 0.
  - set = (accept & regDwe) ? onehot(rD) : 0.
  - sb <= (sb & ~clr) | set. Set wins on same-register collision (the newer write is still pending).
- I_en=0: no accept, no scoreboard update. Writebacks arriving while I_en=0 are lost; the system must not disable the stage with writes outstanding.
- Illegal opcodes are decoded and passed down with O_illegal=1 and O_regDwe=0. They never set the scoreboard.
- Single-entry pipeline register; back-to-back accepts at full rate when I_ready=1 and no hazard.

Test Plan:
- Reset: assert I_rst_n=0 mid-cycle with O_valid=1 → O_valid, O_regDwe, O_imm, scoreboard go 0 immediately, without a clock edge.
- Basic decode: I_instr=16'h0A24 (ADD rD=5, rA=1, rB=1), I_valid=1, I_ready=1 → next cycle O_valid=1, O_selD=5, O_selA=1, O_selB=1, O_regDwe=1, O_aluop=5'b00000, O_imm=16'h0004.
- LOAD high: I_instr=16'h89AB (LOAD flag=1, rD=4) → O_imm=16'hAB00, O_regDwe=1, O_aluop=5'b10001.
- RAW stall: issue ADD writing r5, then instr reading rA=5 → O_ready=0 until I_wb_valid=1, I_wb_sel=5 is seen. O_ready=1 the cycle after writeback, not the same cycle.
- Backpressure: O_valid=1, I_ready=0 for 3 cycles with new I_valid → O_ready=0, outputs bit-stable. Release I_ready → next instruction appears the following cycle.
- Collision/illegal: writeback r3 in the same cycle an instr writing r3 is accepted → sb[3] stays 1. I_instr=16'hF000 → O_illegal=1, O_regDwe=0, scoreboard unchanged.
